// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - R-type request decode and issue controller for a combinational ALU
// Accepts one request at a time, runs it through the ALU for one cycle and returns a tagged response.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;

    state_t             state_q, state_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_illegal_q, rsp_illegal_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    logic [3:0]         dec_op;
    logic               dec_illegal;

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case ({req_funct3, req_funct7b5})
            4'b000_0: dec_op = OP_ADD;
            4'b000_1: dec_op = OP_SUB;
            4'b111_0: dec_op = OP_AND;
            4'b110_0: dec_op = OP_OR;
            4'b100_0: dec_op = OP_XOR;
            default:  dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        tag_d         = tag_q;
        illegal_d     = illegal_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_tag_d     = rsp_tag_q;
        ops_done_d    = ops_done_q;
        req_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Illegal requests still run through the ALU, but on neutral zero operands.
                    alu_op_d  = dec_illegal ? OP_ADD : dec_op;
                    alu_a_d   = dec_illegal ? '0 : req_a;
                    alu_b_d   = dec_illegal ? '0 : req_b;
                    tag_d     = req_tag;
                    illegal_d = dec_illegal;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d  = illegal_q ? '0 : alu_result;
                rsp_zero_d    = illegal_q ? 1'b0 : alu_zero;
                rsp_illegal_d = illegal_q;
                rsp_tag_d     = tag_q;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_op_q      <= OP_ADD;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            tag_q         <= '0;
            illegal_q     <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
            ops_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            tag_q         <= tag_d;
            illegal_q     <= illegal_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_tag_q     <= rsp_tag_d;
            ops_done_q    <= ops_done_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_tag     = rsp_tag_q;
    assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] ops_done;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
        .ops_done(ops_done)
    );

    // Reference combinational ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [3:0] e_op, input logic [31:0] e_res,
                         input logic e_zero, input logic e_ill);
        check_eq({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_funct7b5 = f7;
        req_a = a; req_b = b; req_tag = tag;
        tick();
        req_valid = 1'b0;
        check_eq({name, ".alu_op"}, 32'(alu_op), 32'(e_op));
        check_eq({name, ".alu_a"}, alu_a, e_ill ? 32'd0 : a);
        check_eq({name, ".alu_b"}, alu_b, e_ill ? 32'd0 : b);
        check_eq({name, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({name, ".exec_req_ready"}, 32'(req_ready), 32'd0);
        tick();
        check_eq({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({name, ".rsp_result"}, rsp_result, e_res);
        check_eq({name, ".rsp_zero"}, 32'(rsp_zero), 32'(e_zero));
        check_eq({name, ".rsp_illegal"}, 32'(rsp_illegal), 32'(e_ill));
        check_eq({name, ".rsp_tag"}, 32'(rsp_tag), 32'(tag));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops = (exp_ops + 1) % 16;
        check_eq({name, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_eq({name, ".ops_done"}, 32'(ops_done), 32'(exp_ops));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_funct7b5 = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset.alu_op", 32'(alu_op), 32'd0);
        check_eq("reset.alu_a", alu_a, 32'd0);
        check_eq("reset.alu_b", alu_b, 32'd0);
        check_eq("reset.rsp_result", rsp_result, 32'd0);
        check_eq("reset.rsp_tag", 32'(rsp_tag), 32'd0);
        check_eq("reset.ops_done", 32'(ops_done), 32'd0);
        check_eq("reset.req_ready", 32'(req_ready), 32'd1);

        do_op("add",     3'b000, 1'b0, 32'd10,  32'd5, 4'd3,  4'b0000, 32'd15,         1'b0, 1'b0);
        do_op("sub0",    3'b000, 1'b1, 32'd5,   32'd5, 4'd4,  4'b0001, 32'd0,          1'b1, 1'b0);
        do_op("subwrap", 3'b000, 1'b1, 32'd0,   32'd1, 4'd5,  4'b0001, 32'hFFFF_FFFF,  1'b0, 1'b0);
        do_op("and",     3'b111, 1'b0, 32'hA,   32'h5, 4'd6,  4'b0010, 32'h0,          1'b1, 1'b0);
        do_op("or",      3'b110, 1'b0, 32'hA,   32'h5, 4'd7,  4'b0011, 32'hF,          1'b0, 1'b0);
        do_op("xor",     3'b100, 1'b0, 32'hA,   32'h5, 4'd8,  4'b0100, 32'hF,          1'b0, 1'b0);
        do_op("ill010",  3'b010, 1'b0, 32'd9,   32'd2, 4'd9,  4'b0000, 32'd0,          1'b0, 1'b1);
        do_op("ill111",  3'b111, 1'b1, 32'd7,   32'd3, 4'd10, 4'b0000, 32'd0,          1'b0, 1'b1);

        // Backpressure: response held for 5 cycles while a competing request is offered
        req_valid = 1'b1; req_funct3 = 3'b000; req_funct7b5 = 1'b0;
        req_a = 32'd100; req_b = 32'd23; req_tag = 4'd11;
        tick();
        req_a = 32'd1; req_b = 32'd1; req_tag = 4'd12;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp.rsp_result", rsp_result, 32'd123);
            check_eq("bp.rsp_tag", 32'(rsp_tag), 32'd11);
            check_eq("bp.req_ready", 32'(req_ready), 32'd0);
            check_eq("bp.alu_a", alu_a, 32'd100);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        exp_ops = (exp_ops + 1) % 16;
        check_eq("bp.rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("bp.req_ready_idle", 32'(req_ready), 32'd1);
        check_eq("bp.alu_a_hold", alu_a, 32'd100);
        check_eq("bp.ops_done", 32'(ops_done), 32'(exp_ops));

        // Reset while in EXEC drops the transaction
        req_valid = 1'b1; req_funct3 = 3'b000; req_funct7b5 = 1'b0;
        req_a = 32'd50; req_b = 32'd60; req_tag = 4'd13;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ops = 0;
        check_eq("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rstmid.ops_done", 32'(ops_done), 32'd0);
        check_eq("rstmid.req_ready", 32'(req_ready), 32'd1);
        check_eq("rstmid.alu_a", alu_a, 32'd0);
        check_eq("rstmid.rsp_tag", 32'(rsp_tag), 32'd0);
        tick();
        tick();
        check_eq("rstmid.no_rsp", 32'(rsp_valid), 32'd0);

        // Counter wrap: 16 completions on a 4-bit counter returns to zero
        for (int i = 0; i < 16; i++)
            do_op("wrap", 3'b000, 1'b0, i, 32'd1, 4'(i), 4'b0000, i + 1, 1'b0, 1'b0);
        check_eq("wrap.ops_done_zero", 32'(ops_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
